// File: rtl/cf_gpio_mode_ctrl.sv
// cf_gpio_mode_ctrl
// Runtime mode controller for a single Openframe GPIO pad.
//
// A mode change requested over cfg_valid/cfg_ready moves the pad through
// these steps, so it never drives with a half-applied configuration:
//   DRAIN  - tri-state the pad (one cycle)
//   SWITCH - apply the new drive mode while the pad stays hi-z (SETTLE_CYC cycles)
//   IDLE   - release oeb
// The block also provides a synchronised copy of the pad input.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   cfg_valid/cfg_mode       mode-change request (0..5 valid; 6, 7 rejected)
//   cfg_ready                request can be accepted (IDLE)
//   cfg_done / cfg_err       one-cycle completion / rejection pulses
//   cur_mode, busy           mode in force, transition in progress
//   io_out, io_oeb, io_in    user-side data, output-enable-bar, synced input
//   gpio_in                  raw pad input
//   gpio_dm, gpio_inp_dis,
//   gpio_oeb_out,
//   gpio_out_val             pad configuration and data pins
module cf_gpio_mode_ctrl #(
  parameter logic [2:0] RESET_MODE  = 3'd1,
  parameter int         SETTLE_CYC  = 4,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cfg_valid,
  input  logic [2:0] cfg_mode,
  output logic       cfg_ready,
  output logic       cfg_done,
  output logic       cfg_err,
  output logic [2:0] cur_mode,
  output logic       busy,
  input  logic       io_out,
  input  logic       io_oeb,
  output logic       io_in,
  input  logic       gpio_in,
  output logic [2:0] gpio_dm,
  output logic       gpio_inp_dis,
  output logic       gpio_oeb_out,
  output logic       gpio_out_val
);

  // An out-of-range reset mode falls back to INPUT.
  localparam logic [2:0] RST_MODE = (RESET_MODE > 3'd5) ? 3'd1 : RESET_MODE;
  localparam logic [7:0] CNT_LOAD = 8'(SETTLE_CYC - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRAIN  = 2'd1,
    SWITCH = 2'd2
  } state_t;

  // Pad row packed as {dm[2:0], inp_dis, oeb, out}.
  function automatic logic [5:0] mode_row(input logic [2:0] m, input logic d, input logic oe);
    case (m)
      3'd0:    mode_row = 6'b000_1_1_0;
      3'd1:    mode_row = 6'b001_0_1_0;
      3'd2:    mode_row = 6'b111_0_0_0;
      3'd3:    mode_row = 6'b111_0_0_1;
      3'd4:    mode_row = {3'b110, 1'b1, 1'b0, d};
      3'd5:    mode_row = {3'b110, 1'b0, oe, d};
      default: mode_row = 6'b001_0_1_0;
    endcase
  endfunction

  state_t                 state_q;
  logic [2:0]             cur_mode_q;
  logic [2:0]             tgt_mode_q;
  logic [7:0]             cnt_q;
  logic                   cfg_done_q;
  logic                   cfg_err_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   track_q;
  logic                   io_hold_q;

  logic                   accept;
  logic                   mode_bad;
  logic                   start_xfer;
  logic                   track_d;
  logic [5:0]             cur_row;
  logic [5:0]             tgt_row;

  assign accept     = cfg_valid && (state_q == IDLE);
  assign mode_bad   = (cfg_mode > 3'd5);
  assign start_xfer = accept && !mode_bad && (cfg_mode != cur_mode_q);

  assign cur_row = mode_row(cur_mode_q, io_out, io_oeb);
  assign tgt_row = mode_row(tgt_mode_q, io_out, io_oeb);

  // Tracking only resumes one cycle after IDLE is re-entered, and stops on
  // the very edge that starts a transition.
  assign track_d = (state_q == IDLE) && !start_xfer && !cur_row[2];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cur_mode_q <= RST_MODE;
      tgt_mode_q <= RST_MODE;
      cnt_q      <= '0;
      cfg_done_q <= 1'b0;
      cfg_err_q  <= 1'b0;
    end else begin
      cfg_done_q <= 1'b0;
      cfg_err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            if (mode_bad) begin
              cfg_err_q <= 1'b1;
            end else if (cfg_mode == cur_mode_q) begin
              cfg_done_q <= 1'b1;
            end else begin
              tgt_mode_q <= cfg_mode;
              state_q    <= DRAIN;
            end
          end
        end
        DRAIN: begin
          cnt_q   <= CNT_LOAD;
          state_q <= SWITCH;
        end
        SWITCH: begin
          if (cnt_q == 8'd0) begin
            cur_mode_q <= tgt_mode_q;
            cfg_done_q <= 1'b1;
            state_q    <= IDLE;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q    <= '0;
      track_q   <= 1'b0;
      io_hold_q <= 1'b0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], gpio_in};
      track_q   <= track_d;
      io_hold_q <= io_in;
    end
  end

  assign io_in = track_q ? sync_q[SYNC_STAGES-1] : io_hold_q;

  // Pad pins: oeb is forced high whenever a transition is under way.
  always_comb begin
    gpio_dm      = cur_row[5:3];
    gpio_inp_dis = cur_row[2];
    gpio_oeb_out = cur_row[1];
    gpio_out_val = cur_row[0];
    case (state_q)
      DRAIN: begin
        gpio_oeb_out = 1'b1;
        gpio_out_val = 1'b0;
      end
      SWITCH: begin
        gpio_dm      = tgt_row[5:3];
        gpio_inp_dis = tgt_row[2];
        gpio_oeb_out = 1'b1;
        gpio_out_val = tgt_row[0];
      end
      default: ;
    endcase
  end

  assign cfg_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign cfg_done  = cfg_done_q;
  assign cfg_err   = cfg_err_q;
  assign cur_mode  = cur_mode_q;

endmodule

// File: doc/cf_gpio_mode_ctrl.md
Name: cf_gpio_mode_ctrl

Overview:
Runtime mode controller for one Sky130 Openframe GPIO pad. It accepts mode-change requests over a valid/ready handshake and sequences the pad through a glitch-free transition: tri-state, then switch drive mode, then settle, then enable. It also provides a synchronised pad input. It sits between user logic and the openframe_project_wrapper per-pad config pins, replacing a static mode tie-off where the mode must change after reset.

Parameters:
RESET_MODE, 3'd1, mode applied at reset (same encoding as cfg_mode)
SETTLE_CYC, 4, cycles spent in SWITCH with new dm applied and output still hi-z (legal 1..255)
SYNC_STAGES, 2, flop stages on the gpio_in synchroniser (legal 2..3)

Ports:
clk  input  1  block clock
rst  input  1  synchronous reset, active-high
cfg_valid  input  1  mode-change request valid
cfg_mode  input  3  requested mode: 0 ANALOG, 1 INPUT, 2 INPUT_PD, 3 INPUT_PU, 4 OUTPUT, 5 BIDIR
cfg_ready  output  1  controller can accept a request
cfg_done  output  1  one-cycle pulse when the requested mode is fully applied
cfg_err  output  1  one-cycle pulse when an invalid mode (6 or 7) is presented
cur_mode  output  3  mode currently in force
busy  output  1  transition in progress
io_out  input  1  user data to pad (OUTPUT/BIDIR)
io_oeb  input  1  user output-enable-bar (BIDIR only)
io_in  output  1  synchronised pad input
gpio_in  input  1  raw pad input
gpio_dm  output  3  pad drive mode
gpio_inp_dis  output  1  pad input disable
gpio_oeb_out  output  1  pad output enable bar
gpio_out_val  output  1  pad output value

Behaviour:
- Clock is clk. Reset is synchronous and active-high on rst. All state is sampled on the rising edge of clk.
- Mode table gives {dm, inp_dis, oeb, out}:
  - ANALOG: 000, 1, 1, 0
  - INPUT: 001, 0, 1, 0
  - INPUT_PD: 111, 0, 0, 0
  - INPUT_PU: 111, 0, 0, 1
  - OUTPUT: 110, 1, 0, io_out
  - BIDIR: 110, 0, io_oeb, io_out
- States are IDLE, DRAIN and SWITCH.
- Reset (rst=1):
  - state=IDLE; cur_mode=RESET_MODE; pad outputs take RESET_MODE's table values.
  - cfg_ready=1; cfg_done=0, cfg_err=0, busy=0.
  - Synchroniser flops and io_in are 0.
  - A RESET_MODE of 6 or 7 is treated as INPUT.
  - rst asserted mid-transition aborts the transition and applies the reset values above on the next edge.
- IDLE:
  - cfg_ready=1 and busy=0. Pad outputs follow cur_mode's table row.
  - io_out and io_oeb pass through combinationally in OUTPUT/BIDIR.
- Handshake: a request is accepted when cfg_valid & cfg_ready at a rising edge.
  - cfg_mode 6 or 7: cfg_err=1 the next cycle; no state change; cfg_ready stays 1.
  - cfg_mode equal to cur_mode: cfg_done=1 the next cycle; no transition; pad outputs unchanged and glitch-free.
  - Any other valid mode: the target mode is latched and the FSM moves to DRAIN.
- DRAIN (exactly 1 cycle):
  - oeb=1, out_val=0; dm and inp_dis keep the old mode's values.
  - cfg_ready=0, busy=1. Next state is SWITCH.
- SWITCH (SETTLE_CYC cycles, via a down-counter):
  - dm and inp_dis take the target mode's values; oeb=1.
  - out_val takes the target mode's value (io_out for OUTPUT/BIDIR), giving data setup before oeb is released.
  - When the counter reaches terminal: cur_mode<=target, next state IDLE, and cfg_done=1 in the first IDLE cycle.
- Timing: accept at edge T gives DRAIN during T+1, SWITCH during T+2..T+1+SETTLE_CYC, and IDLE with cfg_done high at T+2+SETTLE_CYC.
- cfg_valid is ignored while cfg_ready=0; no queuing. cfg_done and cfg_err are never high together.
- gpio_oeb_out is never 0 in DRAIN or SWITCH, regardless of io_oeb.
- io_in:
  - io_in is the output of the SYNC_STAGES-flop synchroniser on gpio_in.
  - While busy=1, or while cur_mode's inp_dis=1, io_in holds its last value.
  - io_in resumes tracking the synchroniser the cycle after IDLE is re-entered with inp_dis=0.

Test Plan:
- Reset with RESET_MODE=1 -> gpio_dm=001, inp_dis=0, oeb=1, out_val=0, cur_mode=1, cfg_ready=1, io_in=0.
- In INPUT, request mode 4 at edge T, SETTLE_CYC=4, io_out=1 -> at T+1 oeb=1 and dm=001; T+2..T+5 dm=110, inp_dis=1, oeb=1, out_val=1; at T+6 oeb=0, cur_mode=4, cfg_done=1 for 1 cycle.
- In BIDIR, toggle io_oeb 0/1 while a switch to INPUT_PU runs -> gpio_oeb_out=1 throughout DRAIN/SWITCH; after done dm=111, oeb=0, out_val=1.
- Request mode 7 -> cfg_err pulses 1 cycle; cur_mode and pad outputs unchanged. Request the same mode as current -> cfg_done the next cycle with no output change.
- Assert rst during SWITCH (OUTPUT to ANALOG) -> the next edge restores the RESET_MODE outputs, cfg_ready=1, and no cfg_done. cfg_valid held high while busy -> no second acceptance until IDLE.
- gpio_in toggles while in INPUT -> io_in follows after SYNC_STAGES cycles. In OUTPUT (inp_dis=1) -> io_in frozen.
